// File: rtl/req_queue.sv
// Request FIFO feeding the SPI serializer: buffers {opcode, addr} requests and
// hands them out over a valid/ready handshake with a sticky overflow flag.
module req_queue #(
    parameter int ADDRW   = 8,
    parameter int OPCODEW = 2,
    parameter int DEPTH   = 4,
    localparam int CNTW   = $clog2(DEPTH + 1),
    localparam int PTRW   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [OPCODEW-1:0] in_opcode,
    input  logic [ADDRW-1:0]   in_addr,
    output logic               in_ready,
    output logic               out_valid,
    output logic [OPCODEW-1:0] out_opcode,
    output logic [ADDRW-1:0]   out_addr,
    input  logic               out_ready,
    output logic [CNTW-1:0]    count,
    output logic               overflow
);
    localparam int DW = OPCODEW + ADDRW;

    logic [DW-1:0]   mem_reg [DEPTH];
    logic [PTRW-1:0] wr_ptr_reg;
    logic [PTRW-1:0] rd_ptr_reg;
    logic [CNTW-1:0] count_reg;
    logic [CNTW-1:0] count_next;
    logic            overflow_reg;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Full/empty come from the counter alone, so in_ready never depends on out_ready.
    assign full  = (count_reg == CNTW'(DEPTH));
    assign empty = (count_reg == '0);
    assign push  = in_valid && !full;
    assign pop   = !empty && out_ready;

    assign in_ready   = !full;
    assign out_valid  = !empty;
    assign count      = count_reg;
    assign overflow   = overflow_reg;
    assign {out_opcode, out_addr} = mem_reg[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (push && !flush && (wr_ptr_reg == PTRW'(gi))) begin
                    mem_reg[gi] <= {in_opcode, in_addr};
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNTW'(1);
            2'b01:   count_next = count_reg - CNTW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTRW'(1);
            end
            count_reg <= count_next;
        end
    end

    // Sticky: a rejected push is recorded even in a flush cycle; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (in_valid && full) begin
            overflow_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_req_queue.sv
// Directed bench for req_queue: a table of per-cycle inputs with the outputs
// expected during that cycle, plus hand sequences for reset, mid-burst reset and wrap.
module tb_req_queue;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [1:0] in_opcode;
    logic [7:0] in_addr;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_opcode;
    logic [7:0] out_addr;
    logic       out_ready;
    logic [2:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    req_queue #(.ADDRW(8), .OPCODEW(2), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_opcode(in_opcode), .in_addr(in_addr),
        .in_ready(in_ready), .out_valid(out_valid), .out_opcode(out_opcode),
        .out_addr(out_addr), .out_ready(out_ready), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       fl;
        logic       iv;
        logic [1:0] op;
        logic [7:0] ad;
        logic       ordy;
        int         cnt;
        logic       ov;
        logic [1:0] eop;
        logic [7:0] ead;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic fl, input logic iv, input logic [1:0] op,
                       input logic [7:0] ad, input logic ordy, input int cnt, input logic ov,
                       input logic [1:0] eop, input logic [7:0] ead, input logic ovf);
        vec_t v;
        v.rst = r; v.fl = fl; v.iv = iv; v.op = op; v.ad = ad; v.ordy = ordy;
        v.cnt = cnt; v.ov = ov; v.eop = eop; v.ead = ead; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic fl, input logic iv, input logic [1:0] op,
                         input logic [7:0] ad, input logic ordy);
        rst = r; flush = fl; in_valid = iv; in_opcode = op; in_addr = ad; out_ready = ordy;
    endtask

    initial begin
        // rst fl iv op     ad     ordy cnt ov eop    ead    ovf
        // ordering and latency
        add(0, 0, 1, 2'b01, 8'h3A, 0,   0, 0, 2'b00, 8'h00, 0);
        add(0, 0, 1, 2'b10, 8'h5C, 0,   1, 1, 2'b01, 8'h3A, 0);
        add(0, 0, 0, 2'b00, 8'h00, 1,   2, 1, 2'b01, 8'h3A, 0);
        add(0, 0, 0, 2'b00, 8'h00, 1,   1, 1, 2'b10, 8'h5C, 0);
        add(0, 0, 0, 2'b00, 8'h00, 0,   0, 0, 2'b00, 8'h00, 0);
        // fill, then simultaneous push/pop at full
        add(0, 0, 1, 2'b00, 8'h10, 0,   0, 0, 2'b00, 8'h00, 0);
        add(0, 0, 1, 2'b00, 8'h11, 0,   1, 1, 2'b00, 8'h10, 0);
        add(0, 0, 1, 2'b00, 8'h12, 0,   2, 1, 2'b00, 8'h10, 0);
        add(0, 0, 1, 2'b00, 8'h13, 0,   3, 1, 2'b00, 8'h10, 0);
        add(0, 0, 1, 2'b11, 8'h14, 1,   4, 1, 2'b00, 8'h10, 0);
        add(0, 0, 0, 2'b00, 8'h00, 0,   3, 1, 2'b00, 8'h11, 1);
        add(0, 0, 0, 2'b00, 8'h00, 1,   3, 1, 2'b00, 8'h11, 1);
        add(0, 0, 0, 2'b00, 8'h00, 1,   2, 1, 2'b00, 8'h12, 1);
        add(0, 0, 0, 2'b00, 8'h00, 1,   1, 1, 2'b00, 8'h13, 1);
        add(0, 0, 0, 2'b00, 8'h00, 0,   0, 0, 2'b00, 8'h00, 1);
        add(1, 0, 0, 2'b00, 8'h00, 0,   0, 0, 2'b00, 8'h00, 1);
        add(0, 0, 0, 2'b00, 8'h00, 0,   0, 0, 2'b00, 8'h00, 0);
        // fill, 5th push rejected, drain
        add(0, 0, 1, 2'b00, 8'h10, 0,   0, 0, 2'b00, 8'h00, 0);
        add(0, 0, 1, 2'b00, 8'h11, 0,   1, 1, 2'b00, 8'h10, 0);
        add(0, 0, 1, 2'b00, 8'h12, 0,   2, 1, 2'b00, 8'h10, 0);
        add(0, 0, 1, 2'b00, 8'h13, 0,   3, 1, 2'b00, 8'h10, 0);
        add(0, 0, 1, 2'b00, 8'h14, 0,   4, 1, 2'b00, 8'h10, 0);
        add(0, 0, 0, 2'b00, 8'h00, 1,   4, 1, 2'b00, 8'h10, 1);
        add(0, 0, 0, 2'b00, 8'h00, 1,   3, 1, 2'b00, 8'h11, 1);
        add(0, 0, 0, 2'b00, 8'h00, 1,   2, 1, 2'b00, 8'h12, 1);
        add(0, 0, 0, 2'b00, 8'h00, 1,   1, 1, 2'b00, 8'h13, 1);
        add(0, 0, 0, 2'b00, 8'h00, 1,   0, 0, 2'b00, 8'h00, 1);
        // flush mid-burst with a concurrent push
        add(0, 0, 1, 2'b01, 8'h21, 0,   0, 0, 2'b00, 8'h00, 1);
        add(0, 0, 1, 2'b01, 8'h22, 0,   1, 1, 2'b01, 8'h21, 1);
        add(0, 0, 1, 2'b01, 8'h23, 0,   2, 1, 2'b01, 8'h21, 1);
        add(0, 1, 1, 2'b01, 8'h24, 1,   3, 1, 2'b01, 8'h21, 1);
        add(0, 0, 1, 2'b10, 8'hAA, 0,   0, 0, 2'b00, 8'h00, 1);
        add(0, 0, 0, 2'b00, 8'h00, 0,   1, 1, 2'b10, 8'hAA, 1);
        add(0, 0, 0, 2'b00, 8'h00, 1,   1, 1, 2'b10, 8'hAA, 1);
        add(0, 0, 0, 2'b00, 8'h00, 0,   0, 0, 2'b00, 8'h00, 1);

        // reset for two cycles
        drive(1, 0, 0, 2'b00, 8'h00, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset count", int'(count), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset overflow", int'(overflow), 0);
        chk("reset out_addr", int'(out_addr), 0);
        chk("reset out_opcode", int'(out_opcode), 0);
        $display("txn reset: count=%0d out_valid=%0b in_ready=%0b overflow=%0b",
                 count, out_valid, in_ready, overflow);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].op, vecs[i].ad, vecs[i].ordy);
            #1;
            chk($sformatf("vec%0d count", i), int'(count), vecs[i].cnt);
            chk($sformatf("vec%0d out_valid", i), int'(out_valid), int'(vecs[i].ov));
            chk($sformatf("vec%0d in_ready", i), int'(in_ready), (vecs[i].cnt < 4) ? 1 : 0);
            chk($sformatf("vec%0d overflow", i), int'(overflow), int'(vecs[i].ovf));
            if (vecs[i].ov) begin
                chk($sformatf("vec%0d out_opcode", i), int'(out_opcode), int'(vecs[i].eop));
                chk($sformatf("vec%0d out_addr", i), int'(out_addr), int'(vecs[i].ead));
            end
            $display("txn vec%0d: rst=%0b fl=%0b iv=%0b in=%0h/%02h ordy=%0b -> count=%0d ov=%0b ir=%0b out=%0h/%02h ovf=%0b",
                     i, rst, flush, in_valid, in_opcode, in_addr, out_ready,
                     count, out_valid, in_ready, out_opcode, out_addr, overflow);
        end

        // reset mid-burst: overflow is still set from earlier, held entries vanish
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 0, 1, 2'b11, 8'h31 + 8'(k), 0);
        end
        @(negedge clk);
        drive(1, 0, 1, 2'b11, 8'h34, 1);
        @(negedge clk);
        drive(0, 0, 1, 2'b01, 8'h55, 0);
        #1;
        chk("midrst count", int'(count), 0);
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst in_ready", int'(in_ready), 1);
        chk("midrst overflow", int'(overflow), 0);
        $display("txn midrst: count=%0d ov=%0b ir=%0b ovf=%0b", count, out_valid, in_ready, overflow);
        @(negedge clk);
        drive(0, 0, 0, 2'b00, 8'h00, 1);
        #1;
        chk("midrst first out_valid", int'(out_valid), 1);
        chk("midrst first out_addr", int'(out_addr), 8'h55);
        $display("txn midrst first: out=%0h/%02h", out_opcode, out_addr);
        @(negedge clk);
        drive(0, 0, 0, 2'b00, 8'h00, 0);
        #1;
        chk("midrst drained count", int'(count), 0);

        // wrap-around: push k while popping k-1, count never above 1
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            drive(0, 0, (k < 10), 2'b10, 8'(k), 1);
            #1;
            if (k > 0) begin
                chk($sformatf("wrap%0d out_valid", k), int'(out_valid), 1);
                chk($sformatf("wrap%0d out_addr", k), int'(out_addr), k - 1);
                chk($sformatf("wrap%0d count", k), int'(count), 1);
            end
            $display("txn wrap%0d: in=%02h out=%02h ov=%0b count=%0d", k, in_addr, out_addr, out_valid, count);
        end
        @(negedge clk);
        drive(0, 0, 0, 2'b00, 8'h00, 0);
        #1;
        chk("wrap end count", int'(count), 0);
        chk("wrap end out_valid", int'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
